// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and sizing for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam int ADDR_W_DEF  = 19;
  localparam int INSTR_BYTES = 4;
  localparam int PC_STEP     = 4;

endpackage

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch with run/ok decoder handshake and PC ownership.
// Optional retire counter port enabled by defining FETCH_RETIRE_CNT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        MMemory_rdata,
  output logic [ADDR_W-1:0] MMemory_raddr,
  output logic [31:0]       instr,
  output logic              run,
  input  logic              ok,
  input  logic [31:0]       PC_decode_wdata,
  input  logic              PC_decode_wren,
  input  logic              intr,
  output logic [31:0]       pc,
  output logic              halted
`ifdef FETCH_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  k_r;
  logic [31:0] tgt_r;
  logic        tgt_vld_r;
  logic [31:0] pc_nxt_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and the PC chosen at instruction completion.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc + 32'(PC_STEP);
    // A strobe coincident with ok is the newest target, so it beats the latch.
    if (PC_decode_wren) begin
      pc_nxt_s = PC_decode_wdata;
    end else if (tgt_vld_r) begin
      pc_nxt_s = tgt_r;
    end else begin
      pc_nxt_s = pc + 32'(PC_STEP);
    end
    case (state_r)
      ST_FETCH: begin
        if (k_r == 3'(INSTR_BYTES)) state_nxt_s = ST_EXEC;
        else                        state_nxt_s = ST_FETCH;
      end
      ST_EXEC: begin
        if (ok) state_nxt_s = intr ? ST_HALT : ST_RELEASE;
        else    state_nxt_s = ST_EXEC;
      end
      ST_RELEASE: begin
        if (!ok) state_nxt_s = ST_FETCH;
        else     state_nxt_s = ST_RELEASE;
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Fetch datapath, handshake outputs, PC and redirect latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      MMemory_raddr <= RESET_PC[ADDR_W-1:0];
      instr         <= 32'd0;
      run           <= 1'b0;
      halted        <= 1'b0;
      k_r           <= 3'd0;
      tgt_r         <= 32'd0;
      tgt_vld_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // Memory answers one cycle late, so byte k-1 arrives while k is current.
          if (k_r != 3'd0) instr <= {MMemory_rdata, instr[31:8]};
          if (k_r < 3'd3) MMemory_raddr <= pc[ADDR_W-1:0] + ADDR_W'(k_r + 3'd1);
          if (k_r == 3'(INSTR_BYTES)) begin
            run <= 1'b1;
            k_r <= 3'd0;
          end else begin
            k_r <= k_r + 3'd1;
          end
        end
        ST_EXEC: begin
          if (ok) begin
            run       <= 1'b0;
            pc        <= pc_nxt_s;
            tgt_vld_r <= 1'b0;
            if (intr) halted <= 1'b1;
          end else if (PC_decode_wren) begin
            tgt_r     <= PC_decode_wdata;
            tgt_vld_r <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!ok) begin
            MMemory_raddr <= pc[ADDR_W-1:0];
            k_r           <= 3'd0;
          end
        end
        ST_HALT: begin
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  // Count every instruction the decoder completes, the halting one included.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= 32'd0;
    end else if (state_r == ST_EXEC && ok) begin
      retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: byte memory model, lockstep handshake driver.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rdata;
  logic [18:0] raddr;
  logic [31:0] instr;
  logic        run;
  logic        ok;
  logic [31:0] wdata;
  logic        wren;
  logic        intr;
  logic [31:0] pc;
  logic        halted;

  logic [7:0]  mem [0:524287];
  exp_t        exp_q[$];
  logic        run_d;
  int          n_total;
  int          n_bad;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .MMemory_rdata   (rdata),
    .MMemory_raddr   (raddr),
    .instr           (instr),
    .run             (run),
    .ok              (ok),
    .PC_decode_wdata (wdata),
    .PC_decode_wren  (wren),
    .intr            (intr),
    .pc              (pc),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered read port: data appears the cycle after the address.
  always @(posedge clk) rdata <= mem[raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] p);
    logic [18:0] a;
    a = p[18:0];
    return {mem[a + 19'd3], mem[a + 19'd2], mem[a + 19'd1], mem[a]};
  endfunction

  // On each run rising edge the oldest expected instruction must be presented.
  always @(negedge clk) begin
    if (run === 1'b1 && run_d !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_run", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.word);
        chk("sb_pc", pc, e.pc);
      end
    end
    run_d <= run;
  end

  // Called at the falling edge of the first FETCH cycle; returns in EXEC.
  task automatic do_fetch(input logic [31:0] p, input logic noise);
    exp_q.push_back('{pc: p, word: exp_word(p)});
    for (int i = 0; i < 4; i++) begin
      if (noise) begin
        wren  = 1'b1;
        wdata = 32'hDEAD_0000 + 32'(i);
      end
      chk("raddr", {13'd0, raddr}, {13'd0, p[18:0] + 19'(i)});
      chk("run_low", {31'd0, run}, 32'd0);
      @(negedge clk);
    end
    wren = 1'b0;
    chk("run_k4", {31'd0, run}, 32'd0);
    @(negedge clk);
    chk("run_rise", {31'd0, run}, 32'd1);
  endtask

  // Called in EXEC; returns at the first FETCH cycle unless halting.
  task automatic do_ok(input logic redir, input logic [31:0] tgt, input logic halt,
                       input int hold, input logic [31:0] exp_pc);
    ok    = 1'b1;
    wren  = redir;
    wdata = tgt;
    intr  = halt;
    @(negedge clk);
    wren = 1'b0;
    intr = 1'b0;
    chk("run_drop", {31'd0, run}, 32'd0);
    chk("pc_next", pc, exp_pc);
    chk("halted", {31'd0, halted}, {31'd0, halt});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("run_hold", {31'd0, run}, 32'd0);
    end
    ok = 1'b0;
    if (!halt) @(negedge clk);
  endtask

  initial begin
    logic [18:0] held;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; ok = 1'b0; wren = 1'b0; wdata = 32'd0; intr = 1'b0; run_d = 1'b0;
    for (int i = 0; i < 524288; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;

    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_raddr", {13'd0, raddr}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    do_fetch(32'd0, 1'b0);
    chk("first_instr", instr, 32'h1234_5678);
    do_ok(1'b0, 32'd0, 1'b0, 0, 32'd4);

    // Stray strobes during fetch must be ignored.
    do_fetch(32'd4, 1'b1);
    wren = 1'b1; wdata = 32'h0000_0200;
    @(negedge clk);
    wdata = 32'h0000_0100;
    @(negedge clk);
    wren = 1'b0;
    @(negedge clk);
    chk("run_exec_hold", {31'd0, run}, 32'd1);
    do_ok(1'b0, 32'd0, 1'b0, 0, 32'h0000_0100);

    do_fetch(32'h0000_0100, 1'b0);
    do_ok(1'b1, 32'h0007_FFFE, 1'b0, 3, 32'h0007_FFFE);

    do_fetch(32'h0007_FFFE, 1'b0);
    wren = 1'b1; wdata = 32'hFFFF_FFFC;
    @(negedge clk);
    wren = 1'b0;
    do_ok(1'b0, 32'd0, 1'b0, 0, 32'hFFFF_FFFC);

    do_fetch(32'hFFFF_FFFC, 1'b1);
    do_ok(1'b0, 32'd0, 1'b0, 0, 32'd0);

    do_fetch(32'd0, 1'b0);
    do_ok(1'b0, 32'd0, 1'b1, 0, 32'd4);
    held = 19'd3;
    for (int i = 0; i < 20; i++) begin
      wren  = 1'b1;
      wdata = 32'h0000_0A00 + 32'(i);
      ok    = 1'(i % 2);
      @(negedge clk);
      chk("halt_raddr", {13'd0, raddr}, {13'd0, held});
    end
    wren = 1'b0; ok = 1'b0;
    chk("halt_pc", pc, 32'd4);
    chk("halt_run", {31'd0, run}, 32'd0);
    chk("halt_flag", {31'd0, halted}, 32'd1);

    rst = 1'b1;
    @(negedge clk);
    chk("rst2_pc", pc, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_instr", instr, 32'd0);
    rst = 1'b0;
    chk("part_raddr0", {13'd0, raddr}, 32'd0);
    @(negedge clk);
    chk("part_raddr1", {13'd0, raddr}, 32'd1);
    @(negedge clk);
    chk("part_raddr2", {13'd0, raddr}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_run", {31'd0, run}, 32'd0);
    chk("midrst_raddr", {13'd0, raddr}, 32'd0);
    rst = 1'b0;

    do_fetch(32'd0, 1'b0);
    do_ok(1'b0, 32'd0, 1'b0, 0, 32'd4);
    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
